// File: rtl/icache_assoc_refill.sv
// N-way set-associative instruction cache with multi-word lines.
// Hits answer combinationally in the request cycle. A miss runs a refill
// that reads the whole line one word at a time over a req/ack port,
// installs it, and lets the held request hit on the following cycle.
// A flush_i pulse invalidates every line.
module icache_assoc_refill #(
    parameter int ADDR_W     = 17,
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_inst_o,
    output logic        busy_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    localparam int OFF     = $clog2(LINE_WORDS);
    localparam int IDX     = $clog2(SETS);
    localparam int TAG_LSB = OFF + IDX + 2;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d;
    logic [SETS-1:0][WAY_W-1:0] ptr_q, ptr_d;
    logic [WAY_W-1:0]           vway_q, vway_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       mem_req_q, mem_req_d;
    logic [31:0]                mem_addr_q, mem_addr_d;
    logic                       busy_q, busy_d;

    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][SETS][LINE_WORDS];

    // Request address fields.
    logic [OFF-1:0]   req_off;
    logic [IDX-1:0]   req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      line_base;
    assign req_off   = req_addr_i[OFF+1:2];
    assign req_idx   = req_addr_i[TAG_LSB-1:OFF+2];
    assign req_tag   = req_addr_i[ADDR_W-1:TAG_LSB];
    assign line_base = {{(32-ADDR_W){1'b0}}, req_addr_i[ADDR_W-1:OFF+2], {(OFF+2){1'b0}}};

    // The refill target set, tag and word offset all live in the held memory address.
    logic [OFF-1:0]   fill_off;
    logic [IDX-1:0]   fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             last_word;
    assign fill_off  = mem_addr_q[OFF+1:2];
    assign fill_idx  = mem_addr_q[TAG_LSB-1:OFF+2];
    assign fill_tag  = mem_addr_q[ADDR_W-1:TAG_LSB];
    assign last_word = &fill_off;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[31:ADDR_W], req_addr_i[1:0],
                                mem_addr_q[31:ADDR_W], mem_addr_q[1:0]};

    logic             hit;
    logic             match;
    logic [WAY_W-1:0] hit_way;

    // Tag compare across the ways of the set; the lowest matching way wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        match   = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
                match   = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit = match && req_valid_i && (state_q == IDLE);
    end

    assign resp_valid_o = hit;
    assign resp_inst_o  = hit ? data_mem[hit_way][req_idx][req_off] : 32'd0;

    logic             set_full;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W-1:0] ptr_cur;
    logic [WAY_W-1:0] ptr_next;

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        set_full   = &valid_q[req_idx];
        ptr_cur    = ptr_q[req_idx];
        ptr_next   = (ptr_cur == WAY_W'(WAYS - 1)) ? '0 : ptr_cur + WAY_W'(1);
        victim_way = ptr_cur;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    // Next-state logic for the refill FSM, valid bits and victim pointers.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        ptr_d        = ptr_q;
        vway_d       = vway_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && !hit && !flush_i) begin
                    state_d      = REFILL;
                    vway_d       = victim_way;
                    flush_pend_d = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = line_base;
                    busy_d       = 1'b1;
                    if (set_full) begin
                        ptr_d[req_idx] = ptr_next;
                    end
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    if (last_word) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        busy_d    = 1'b0;
                        if (!flush_pend_q && !flush_i) begin
                            valid_d[fill_idx][vway_q] = 1'b1;
                        end
                    end else begin
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush mid-refill still drains the line but leaves it invalid.
        if (flush_i) begin
            valid_d = '0;
            if (state_q == REFILL) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            ptr_q        <= '0;
            vway_q       <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            ptr_q        <= ptr_d;
            vway_q       <= vway_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
        end
    end

    // Capture each acked word; write the tag with the last word.
    always_ff @(posedge clk) begin
        // NOTE: tag/data arrays are not reset; the valid bits alone decide what can hit.
        if (!rst && (state_q == REFILL) && mem_ack_i) begin
            data_mem[vway_q][fill_idx][fill_off] <= mem_data_i;
            if (last_word) begin
                tag_mem[vway_q][fill_idx] <= fill_tag;
            end
        end
    end

    assign busy_o     = busy_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_icache_assoc_refill.sv
// Directed plus random bench for icache_assoc_refill (default geometry).
// Expected fetch results and refill addresses go into queues when a fetch
// is issued; the memory responder and the response wait pop and compare.
module tb_icache_assoc_refill;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [31:0] req_addr_i;
    logic        resp_valid_o;
    logic [31:0] resp_inst_o;
    logic        busy_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    logic        auto_mem;
    logic        resp_ack, man_ack;
    logic [31:0] resp_data, man_data;
    int          ack_delay;
    int          wait_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];

    assign mem_ack_i  = resp_ack | man_ack;
    assign mem_data_i = auto_mem ? resp_data : man_data;

    always #5 clk = ~clk;

    icache_assoc_refill #(
        .ADDR_W(17), .WAYS(2), .SETS(32), .LINE_WORDS(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .resp_valid_o(resp_valid_o), .resp_inst_o(resp_inst_o),
        .busy_o(busy_o), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[16:2], 2'b01, a[16:2] ^ 15'h2A5B};
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & 32'h0001_FFFF & ~(32'(LW * 4) - 32'd1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: acks a pending word after ack_delay idle cycles and
    // checks its address against the expected refill sequence.
    initial begin
        resp_ack  = 1'b0;
        resp_data = '0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (auto_mem && (mem_req_o === 1'b1) && !rst) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt  = 0;
                    resp_ack  = 1'b1;
                    resp_data = mem_word(mem_addr_o);
                    if (exp_addr_q.size() == 0)
                        check("mem_req without pending miss", 32'(mem_req_o), 32'd0);
                    else
                        check("mem_addr_o", mem_addr_o, exp_addr_q.pop_front());
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_resp(input string tag, output int lat);
        lat = 0;
        #1;
        while ((resp_valid_o !== 1'b1) && (lat < 300)) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, " resp_valid"}, 32'(resp_valid_o), 32'd1);
        if (exp_inst_q.size() > 0)
            check({tag, " inst"}, resp_inst_o, exp_inst_q.pop_front());
    endtask

    // mode 0: must hit, 1: must miss and refill, 2: either (random stream).
    task automatic fetch(input logic [31:0] addr, input int mode, input int exp_lat,
                         input string tag);
        int lat;
        int sz;
        if (mode != 0)
            for (int k = 0; k < LW; k++) exp_addr_q.push_back(base_of(addr) + 32'(4 * k));
        exp_inst_q.push_back(mem_word(addr));
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        wait_resp(tag, lat);
        req_valid_i = 1'b0;
        sz = exp_addr_q.size();
        case (mode)
            0:       check({tag, " hit latency"}, 32'(lat), 32'd0);
            1:       check({tag, " refill words left"}, 32'(sz), 32'd0);
            default: check({tag, " hit/refill"},
                           32'(((sz == 0) && (lat > 0)) || ((sz == LW) && (lat == 0))), 32'd1);
        endcase
        if (exp_lat >= 0) check({tag, " miss latency"}, 32'(lat), 32'(exp_lat));
        exp_addr_q.delete();
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        rst = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; flush_i = 1'b0;
        auto_mem = 1'b1; man_ack = 1'b0; man_data = '0; ack_delay = 2;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset resp_valid", 32'(resp_valid_o), 32'd0);
        check("reset resp_inst", resp_inst_o, 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset mem_req", 32'(mem_req_o), 32'd0);
        check("reset mem_addr", mem_addr_o, 32'd0);

        // Cold miss, then every word of the line hits.
        fetch(32'h0104, 1, LW * (2 + 1) + 1, "cold");
        for (int k = 0; k < LW; k++) fetch(32'h0100 + 32'(4 * k), 0, -1, "cold line");

        // Associativity and round-robin eviction in set 16.
        ack_delay = 0;
        fetch(32'h2100, 1, -1, "fill 2100");
        fetch(32'h0100, 0, -1, "keep 0100");
        fetch(32'h2104, 0, -1, "keep 2104");
        fetch(32'h4100, 1, -1, "evict way0");
        fetch(32'h2100, 0, -1, "way1 kept");
        fetch(32'h4104, 0, -1, "4100 line");
        fetch(32'h6100, 1, -1, "evict way1");
        fetch(32'h4100, 0, -1, "way0 kept");
        fetch(32'h2100, 1, -1, "evict way0 again");
        fetch(32'h6100, 0, -1, "6100 kept");

        // Flush in IDLE: same-cycle lookup still sees old contents.
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 32'h6100; flush_i = 1'b1;
        #1;
        check("flush cycle hit", 32'(resp_valid_o), 32'd1);
        check("flush cycle inst", resp_inst_o, mem_word(32'h6100));
        @(negedge clk);
        flush_i = 1'b0; req_valid_i = 1'b0;
        fetch(32'h6100, 1, -1, "post-flush 6100");
        fetch(32'h2100, 1, -1, "post-flush 2100");

        // Flush on the 2nd ack of a refill: drains all words, no install.
        auto_mem = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 32'h0200;
        @(negedge clk);
        #1;
        for (int k = 0; k < LW; k++) begin
            check("flushref addr", mem_addr_o, 32'h0200 + 32'(4 * k));
            man_ack = 1'b1; man_data = mem_word(32'h0200 + 32'(4 * k)); flush_i = (k == 1);
            @(negedge clk);
            man_ack = 1'b0; flush_i = 1'b0;
            #1;
            if (k < LW - 1) check("flushref mem_req held", 32'(mem_req_o), 32'd1);
        end
        check("flushref mem_req drop", 32'(mem_req_o), 32'd0);
        check("flushref no hit", 32'(resp_valid_o), 32'd0);
        @(negedge clk);
        #1;
        check("flushref re-miss req", 32'(mem_req_o), 32'd1);
        check("flushref re-miss addr", mem_addr_o, 32'h0200);
        for (int k = 0; k < LW; k++) exp_addr_q.push_back(32'h0200 + 32'(4 * k));
        exp_inst_q.push_back(mem_word(32'h0200));
        ack_delay = 1;
        auto_mem  = 1'b1;
        wait_resp("flushref refill", lat);
        req_valid_i = 1'b0;
        check("flushref words left", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();

        // Reset mid-refill.
        auto_mem = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 32'h0300;
        @(negedge clk);
        #1;
        check("rstref first addr", mem_addr_o, 32'h0300);
        man_ack = 1'b1; man_data = mem_word(32'h0300);
        @(negedge clk);
        man_ack = 1'b0; rst = 1'b1; req_valid_i = 1'b0;
        #1;
        check("rstref advanced", mem_addr_o, 32'h0304);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstref mem_req", 32'(mem_req_o), 32'd0);
        check("rstref mem_addr", mem_addr_o, 32'd0);
        check("rstref busy", 32'(busy_o), 32'd0);
        check("rstref resp_valid", 32'(resp_valid_o), 32'd0);
        check("rstref resp_inst", resp_inst_o, 32'd0);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        #1;
        check("stray ack mem_req", 32'(mem_req_o), 32'd0);
        check("stray ack busy", 32'(busy_o), 32'd0);
        auto_mem = 1'b1;
        fetch(32'h0300, 1, -1, "after reset 0300");
        fetch(32'h0200, 1, -1, "reset cleared 0200");

        // Backpressure: ack withheld, request dropped partway.
        auto_mem = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 32'h0404;
        @(negedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("bp mem_req", 32'(mem_req_o), 32'd1);
            check("bp mem_addr", mem_addr_o, 32'h0400);
            check("bp busy", 32'(busy_o), 32'd1);
            check("bp resp_valid", 32'(resp_valid_o), 32'd0);
            if (i == 5) req_valid_i = 1'b0;
            @(negedge clk);
            #1;
        end
        for (int k = 0; k < LW; k++) exp_addr_q.push_back(32'h0400 + 32'(4 * k));
        ack_delay = 0;
        auto_mem  = 1'b1;
        lat = 0;
        while ((busy_o !== 1'b0) && (lat < 100)) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("bp refill done", 32'(busy_o), 32'd0);
        check("bp words left", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        fetch(32'h0404, 0, -1, "bp installed");
        fetch(32'h040C, 0, -1, "bp last word");

        // Random fetch stream over a small conflicting footprint.
        for (int i = 0; i < 60; i++) begin
            ack_delay = int'($urandom_range(0, 3));
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            fetch(a, 2, -1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
